// File: rtl/wimax_pkg.sv
// Shared sizes, generator polynomials and FSM state type for the WiMAX FEC chain.
package wimax_pkg;

    localparam int BLOCK_BITS = 96;
    localparam int CODED_BITS = 192;
    localparam int CC_K       = 7;
    localparam int CNT_W      = 7;

    localparam logic [CC_K-1:0] CC_G1 = 7'o171;
    localparam logic [CC_K-1:0] CC_G2 = 7'o133;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ENCODE = 2'd2
    } fec_state_t;

endpackage

// File: rtl/cc_enc_core.sv
// Combinational K=7 convolutional encoder core: shift-register state plus current bit -> (X, Y).
module cc_enc_core
    import wimax_pkg::*;
(
    input  logic [CC_K-2:0] i_state,
    input  logic            i_bit,
    output logic            o_x,
    output logic            o_y
);

    // Generator MSB is delay 0, LSB is delay 6; i_state[0] holds delay 1.
    logic [CC_K-1:0] w_taps;

    assign w_taps[CC_K-1] = i_bit;

    generate
        for (genvar gi = 0; gi < CC_K-1; gi++) begin : g_taps
            assign w_taps[CC_K-2-gi] = i_state[gi];
        end
    endgenerate

    assign o_x = ^(w_taps & CC_G1);
    assign o_y = ^(w_taps & CC_G2);

endmodule

// File: rtl/fec_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder: collects 96-bit blocks, emits 192 coded bits.
module fec_encoder
    import wimax_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic valid_in,
    input  logic data_in,
    output logic ready_out,
    output logic valid_out,
    output logic q,
    input  logic ready_in
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BITS - 1);

    fec_state_t             r_state;
    fec_state_t             w_state_next;
    logic [CNT_W-1:0]       r_in_cnt;
    logic [CNT_W-1:0]       r_out_cnt;
    logic                   r_phase;
    logic [CC_K-2:0]        r_enc_state;
    logic [BLOCK_BITS-1:0]  r_block;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last_in;
    logic                   w_last_out;
    logic                   w_cur_bit;
    logic                   w_x;
    logic                   w_y;
    logic [CC_K-2:0]        w_preload;

    // Fire terms come from the state register so they never loop through the output logic.
    assign w_in_fire  = valid_in && (r_state == LOAD);
    assign w_out_fire = ready_in && (r_state == ENCODE);
    assign w_last_in  = w_in_fire && (r_in_cnt == LAST_IDX);
    assign w_last_out = w_out_fire && r_phase && (r_out_cnt == LAST_IDX);
    assign w_cur_bit  = r_block[r_out_cnt];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        ready_out    = 1'b0;
        valid_out    = 1'b0;
        unique case (r_state)
            IDLE: w_state_next = LOAD;
            LOAD: begin
                ready_out = 1'b1;
                if (w_last_in) w_state_next = ENCODE;
            end
            ENCODE: begin
                valid_out = 1'b1;
                if (w_last_out) w_state_next = LOAD;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)        r_in_cnt <= '0;
        else if (w_in_fire) r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_out_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_out_fire) begin
            r_phase <= ~r_phase;
            if (r_phase) r_out_cnt <= w_last_out ? '0 : r_out_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) r_block[r_in_cnt] <= data_in;
    end

    // Bit 95 is still on data_in when the tail-biting preload happens.
    assign w_preload[0] = data_in;
    generate
        for (genvar gi = 1; gi < CC_K-1; gi++) begin : g_preload
            assign w_preload[gi] = r_block[BLOCK_BITS-1-gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                    r_enc_state <= '0;
        else if (w_last_in)             r_enc_state <= w_preload;
        else if (w_out_fire && r_phase) r_enc_state <= {r_enc_state[CC_K-3:0], w_cur_bit};
    end

    cc_enc_core u_core (
        .i_state (r_enc_state),
        .i_bit   (w_cur_bit),
        .o_x     (w_x),
        .o_y     (w_y)
    );

    assign q = (r_state == ENCODE) && (r_phase ? w_y : w_x);

endmodule

// File: tb/tb_fec_encoder.sv
// Self-checking bench for fec_encoder: directed patterns, random blocks with backpressure, mid-block reset.
module tb_fec_encoder;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic valid_in = 1'b0;
    logic data_in = 1'b0;
    logic ready_in = 1'b1;
    logic ready_out;
    logic valid_out;
    logic q;

    int n_cmp = 0;
    int n_fail = 0;

    fec_encoder dut (
        .clk       (clk),
        .resetN    (resetN),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .q         (q),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: each output pair is the XOR of the generator-selected bits, indices taken modulo 96.
    function automatic logic [191:0] ref_encode(input logic [95:0] b);
        logic [191:0] r;
        int g1[5] = '{0, 1, 2, 3, 6};
        int g2[5] = '{0, 2, 3, 5, 6};
        logic x;
        logic y;
        r = '0;
        for (int i = 0; i < 96; i++) begin
            x = 1'b0;
            y = 1'b0;
            for (int j = 0; j < 5; j++) begin
                x = x ^ b[(i - g1[j] + 96) % 96];
                y = y ^ b[(i - g2[j] + 96) % 96];
            end
            r[2*i]   = x;
            r[2*i+1] = y;
        end
        return r;
    endfunction

    task automatic load_block(input logic [95:0] b, input bit gaps);
        int idx = 0;
        int cyc = 0;
        while (idx < 96) begin
            if (cyc >= 1000) begin
                check("load_timeout", 1'b1, 1'b0);
                break;
            end
            valid_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_in  = b[idx];
            if (ready_out) check("valid_out_in_load", valid_out, 1'b0);
            if (valid_in && ready_out) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic collect(input logic [191:0] exp, input bit rnd_rdy, input int stop_at);
        int k = 0;
        int cyc = 0;
        logic prev_q = 1'b0;
        logic prev_stall = 1'b0;
        logic r;
        while (k < stop_at) begin
            if (cyc >= 2000) begin
                check("collect_timeout", 1'b1, 1'b0);
                break;
            end
            check("valid_out", valid_out, 1'b1);
            check("ready_out_encode", ready_out, 1'b0);
            check($sformatf("q[%0d]", k), q, exp[k]);
            if (prev_stall) check("q_hold", q, prev_q);
            r = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_in = r;
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 1'($urandom_range(0, 1));
            prev_q     = q;
            prev_stall = !r;
            @(posedge clk);
            #1;
            cyc++;
            if (r) k++;
        end
        ready_in = 1'b1;
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic run_block(input string name, input logic [95:0] b, input logic [191:0] exp,
                             input bit gaps, input bit rnd_rdy);
        int f0;
        f0 = n_fail;
        load_block(b, gaps);
        collect(exp, rnd_rdy, 192);
        check("valid_out_after_block", valid_out, 1'b0);
        check("ready_out_after_block", ready_out, 1'b1);
        $display("block %-10s in=%h failures=%0d", name, b, n_fail - f0);
    endtask

    initial begin
        logic [95:0]  b;
        logic [191:0] e;
        bit x0[7] = '{1, 1, 1, 1, 0, 0, 1};
        bit y0[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit xt[6] = '{1, 1, 1, 0, 0, 1};
        bit yt[6] = '{0, 1, 1, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_ready_out", ready_out, 1'b0);
        check("rst_q", q, 1'b0);
        resetN = 1'b1;
        #1;
        check("idle_ready_out", ready_out, 1'b0);
        @(posedge clk);
        #1;
        check("load_ready_out", ready_out, 1'b1);

        run_block("zeros", '0, '0, 1'b0, 1'b0);
        run_block("ones", '1, '1, 1'b1, 1'b0);

        b = '0;
        b[0] = 1'b1;
        e = '0;
        for (int i = 0; i < 7; i++) begin
            e[2*i]   = x0[i];
            e[2*i+1] = y0[i];
        end
        run_block("bit0", b, e, 1'b1, 1'b1);

        b = '0;
        b[95] = 1'b1;
        e = '0;
        for (int i = 0; i < 6; i++) begin
            e[2*i]   = xt[i];
            e[2*i+1] = yt[i];
        end
        e[190] = 1'b1;
        e[191] = 1'b1;
        run_block("bit95", b, e, 1'b1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            b = {$urandom, $urandom, $urandom};
            run_block($sformatf("random%0d", t), b, ref_encode(b), 1'b1, 1'b1);
        end

        // Abort a block at out_cnt=40 and confirm the next one carries no residue.
        b = {$urandom, $urandom, $urandom};
        load_block(b, 1'b1);
        collect(ref_encode(b), 1'b1, 80);
        resetN = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 1'b0);
        check("midrst_ready_out", ready_out, 1'b0);
        check("midrst_q", q, 1'b0);
        $display("block %-10s in=%h reset after 80 coded bits", "aborted", b);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        b = {$urandom, $urandom, $urandom};
        run_block("post_reset", b, ref_encode(b), 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
